// File: rtl/gate_truth_table_checker_if.sv
// gate_truth_table_checker_if: start/expected request, gate drive and result signals of the checker
interface gate_truth_table_checker_if;
   logic       start;
   logic [3:0] expected;
   logic       z_in;
   logic       e_out;
   logic       f_out;
   logic [1:0] vec_idx;
   logic       busy;
   logic       done;
   logic       pass;
   logic [3:0] fail_vec;
   modport master (
      output start, expected, z_in,
      input  e_out, f_out, vec_idx, busy, done, pass, fail_vec
   );
   modport slave (
      input  start, expected, z_in,
      output e_out, f_out, vec_idx, busy, done, pass, fail_vec
   );
endinterface

// File: rtl/gate_truth_table_checker.sv
// gate_truth_table_checker: walks the four {E,F} vectors of a 2-input gate and checks Z against a truth table
module gate_truth_table_checker #(
   parameter int SETTLE_CYCLES = 10
) (
   input logic                       clk,
   input logic                       rst_n,
   gate_truth_table_checker_if.slave bus
);
   localparam int CW = $clog2(SETTLE_CYCLES + 1);
   localparam logic [CW-1:0] RELOAD = CW'(SETTLE_CYCLES - 1);
   typedef enum logic [1:0] {IDLE, SETTLE, DONE} state_t;
   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [3:0]    exp_q, exp_d, fail_q, fail_d, fv;
   logic [1:0]    idx_q, idx_d;
   logic          busy_q, busy_d, done_q, done_d, pass_q, pass_d;
   // state and registered outputs
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         exp_q   <= '0;
         fail_q  <= '0;
         idx_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         exp_q   <= exp_d;
         fail_q  <= fail_d;
         idx_q   <= idx_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         pass_q  <= pass_d;
      end
   end
   // next state: settle countdown, compare at count zero, advance vector or finish
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      exp_d   = exp_q;
      fail_d  = fail_q;
      idx_d   = idx_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      pass_d  = pass_q;
      fv      = fail_q;
      fv[idx_q] = fail_q[idx_q] | (bus.z_in != exp_q[idx_q]);
      case (state_q)
         IDLE: if (bus.start) begin
            exp_d   = bus.expected;
            idx_d   = 2'd0;
            fail_d  = 4'b0;
            pass_d  = 1'b0;
            cnt_d   = RELOAD;
            busy_d  = 1'b1;
            state_d = SETTLE;
         end
         SETTLE: if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
         end else begin
            fail_d = fv;
            if (idx_q != 2'd3) begin
               idx_d = idx_q + 2'd1;
               cnt_d = RELOAD;
            end else begin
               state_d = DONE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               pass_d  = (fv == 4'b0);
               idx_d   = 2'd0;
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   assign bus.e_out    = idx_q[1];
   assign bus.f_out    = idx_q[0];
   assign bus.vec_idx  = idx_q;
   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.pass     = pass_q;
   assign bus.fail_vec = fail_q;
endmodule

// File: tb/tb_gate_truth_table_checker.sv
// tb_gate_truth_table_checker: drives an OR-gate model through the checker and compares against a timeline model
module tb_gate_truth_table_checker;
   localparam int S = 10;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;
   gate_truth_table_checker_if bus ();
   gate_truth_table_checker #(.SETTLE_CYCLES(S)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   logic [3:0]  delay = 4'd0;
   logic [15:0] pipe = '0;
   // gate under test: OR with an optional delay line of `delay` cycles
   always @(posedge clk) pipe <= {pipe[14:0], bus.e_out | bus.f_out};
   assign bus.z_in = (delay == 4'd0) ? (bus.e_out | bus.f_out) : pipe[delay - 4'd1];
   int errors = 0;
   int checks = 0;
   int cyc = 0;
   bit chk_en = 1'b0;
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask
   // which vectors must mismatch: the gate output seen at vector j's sampling edge
   function automatic logic [3:0] mm_of(input logic [3:0] e, input int d);
      logic [3:0] mm;
      for (int j = 0; j < 4; j++) begin
         int t, src;
         t = (j + 1) * S - d - 1;
         src = (d == 0) ? j : ((t < 0) ? -1 : t / S);
         mm[j] = (src > 0) != e[j];
      end
      return mm;
   endfunction
   bit         m_on = 1'b0;
   int         m_t0 = 0;
   logic [3:0] m_mm = '0;
   // model: record accepted runs (start edge, latched table outcome)
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (!rst_n) m_on <= 1'b0;
      else if (bus.start && (!m_on || (cyc + 1 - m_t0) >= 4 * S + 2)) begin
         m_on <= 1'b1;
         m_t0 <= cyc + 1;
         m_mm <= mm_of(bus.expected, int'(delay));
      end
   end
   int         k;
   logic       e_busy, e_done, e_pass;
   logic [1:0] e_vec;
   logic [3:0] e_fail;
   // compare every cycle against the timeline derived from the run start
   always @(negedge clk) if (chk_en) begin
      k = cyc - m_t0;
      e_busy = m_on && k < 4 * S;
      e_vec  = e_busy ? 2'(k / S) : 2'd0;
      e_done = m_on && k == 4 * S;
      e_pass = m_on && k >= 4 * S && m_mm == 4'b0;
      for (int j = 0; j < 4; j++) e_fail[j] = m_on && k >= (j + 1) * S && m_mm[j];
      check("busy", 32'(bus.busy), 32'(e_busy));
      check("done", 32'(bus.done), 32'(e_done));
      check("vec_idx", 32'(bus.vec_idx), 32'(e_vec));
      check("e_out", 32'(bus.e_out), 32'(e_vec[1]));
      check("f_out", 32'(bus.f_out), 32'(e_vec[0]));
      check("pass", 32'(bus.pass), 32'(e_pass));
      check("fail_vec", 32'(bus.fail_vec), 32'(e_fail));
   end
   task automatic run(input logic [3:0] e, input bit hold, output int t0);
      bus.expected = e;
      bus.start = 1'b1;
      @(negedge clk);
      t0 = cyc;
      if (!hold) bus.start = 1'b0;
   endtask
   task automatic wait_done(input int t0);
      int n = 0;
      while (bus.done !== 1'b1 && n < 4 * S + 20) begin
         @(negedge clk);
         n++;
      end
      check("done_latency", 32'(cyc - t0), 32'(4 * S));
   endtask
   int t0;
   initial begin
      bus.start = 1'b1;
      bus.expected = 4'b1110;
      repeat (3) @(negedge clk);
      chk_en = 1'b1;
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_done", 32'(bus.done), 32'd0);
      check("rst_pass", 32'(bus.pass), 32'd0);
      check("rst_fail", 32'(bus.fail_vec), 32'd0);
      check("rst_ef", 32'({bus.e_out, bus.f_out, bus.vec_idx}), 32'd0);
      rst_n = 1'b1;
      bus.start = 1'b0;
      repeat (2) @(negedge clk);
      run(4'b1110, 1'b0, t0);
      repeat (S + 2) @(negedge clk);
      check("walk_ef01", 32'({bus.e_out, bus.f_out}), 32'd1);
      wait_done(t0);
      check("or_pass", 32'(bus.pass), 32'd1);
      check("or_fail", 32'(bus.fail_vec), 32'b0000);
      repeat (3) @(negedge clk);
      run(4'b1000, 1'b0, t0);
      wait_done(t0);
      check("and_pass", 32'(bus.pass), 32'd0);
      check("and_fail", 32'(bus.fail_vec), 32'b0110);
      repeat (5) @(negedge clk);
      check("and_fail_held", 32'(bus.fail_vec), 32'b0110);
      delay = 4'd12;
      repeat (15) @(negedge clk);
      run(4'b1110, 1'b0, t0);
      wait_done(t0);
      check("dly_pass", 32'(bus.pass), 32'd0);
      check("dly_fail", 32'(bus.fail_vec), 32'b0010);
      @(negedge clk);
      delay = 4'd0;
      repeat (3) @(negedge clk);
      run(4'b1110, 1'b1, t0);
      repeat (4) @(negedge clk);
      bus.expected = 4'b0000;
      wait_done(t0);
      check("hold_pass", 32'(bus.pass), 32'd1);
      @(negedge clk);
      check("hold_ignored_in_done", 32'(bus.busy), 32'd0);
      @(negedge clk);
      check("hold_rerun_busy", 32'(bus.busy), 32'd1);
      bus.start = 1'b0;
      wait_done(t0 + 4 * S + 2);
      check("rerun_fail", 32'(bus.fail_vec), 32'b1110);
      check("rerun_pass", 32'(bus.pass), 32'd0);
      repeat (3) @(negedge clk);
      bus.expected = 4'b1110;
      run(4'b1110, 1'b0, t0);
      repeat (14) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      check("abort_busy", 32'(bus.busy), 32'd0);
      check("abort_ef", 32'({bus.e_out, bus.f_out}), 32'd0);
      check("abort_fail", 32'(bus.fail_vec), 32'd0);
      check("abort_done", 32'(bus.done), 32'd0);
      rst_n = 1'b1;
      repeat (4 * S + 5) @(negedge clk);
      check("abort_no_done", 32'(bus.done), 32'd0);
      run(4'b1110, 1'b0, t0);
      wait_done(t0);
      check("after_abort_pass", 32'(bus.pass), 32'd1);
      check("after_abort_fail", 32'(bus.fail_vec), 32'd0);
      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
